// File: rtl/riscv_defines.sv
// riscv_defines: shared store-path types, FSM states and byte-mask constants
package riscv_defines;
    typedef enum logic [1:0] {STORE_SB, STORE_SH, STORE_SW} StoreOp_t;
    typedef enum logic [1:0] {IDLE, LO, HI} store_state_t;
    localparam logic [3:0] MASK_SB = 4'b0001;
    localparam logic [3:0] MASK_SH = 4'b0011;
    localparam logic [3:0] MASK_SW = 4'b1111;
    function automatic logic [3:0] store_mask(input StoreOp_t op);
        return op == STORE_SB ? MASK_SB : op == STORE_SH ? MASK_SH : MASK_SW;
    endfunction
endpackage

// File: rtl/store_alignment_unit_align.sv
// store_alignment: shifts store data and byte mask into lane position across two words
module store_alignment
    import riscv_defines::*;
(
    input  logic [1:0]  off,
    input  StoreOp_t    op,
    input  logic [31:0] data,
    output logic [63:0] data64,
    output logic [7:0]  strb8
);
    logic [3:0]  mask;
    logic [31:0] lanes;
    // zero bytes beyond the access width, then shift data and strobe by the byte offset
    always_comb begin
        mask   = store_mask(op);
        lanes  = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        data64 = {32'b0, lanes} << {off, 3'b000};
        strb8  = {4'b0000, mask} << off;
    end
endmodule

// File: rtl/store_alignment_unit.sv
// store_alignment_unit: M-stage store to lane-aligned word writes; KIANV_MISALIGNED_STORE_SPLIT_EN enables cross-word split
module store_alignment_unit
    import riscv_defines::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StoreReqM,
    input  StoreOp_t        StoreOpM,
    input  logic [XLEN-1:0] AddrM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            StallM,
    output logic            StoreDoneM,
    output logic            StoreMisalignedM,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb
);
    store_state_t state, state_n;
    logic [63:0]  data64;
    logic [7:0]   strb8;
    logic         valid_n, need_hi, hs, final_hs, misaligned, hi_pend, accept;
    logic [31:0]  addr_n, wdata_n;
    logic [3:0]   wstrb_n;

    store_alignment u_align (
        .off    (AddrM[1:0]),
        .op     (StoreOpM),
        .data   (WriteDataM),
        .data64 (data64),
        .strb8  (strb8)
    );

    assign need_hi  = |strb8[7:4];
    assign hs       = mem_valid && mem_ready;
    assign final_hs = hs && (state == HI || !hi_pend);
    assign accept   = state == IDLE && StoreReqM && !misaligned;

`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
    logic [31:0] hi_addr, hi_wdata;
    logic [3:0]  hi_wstrb;
    assign misaligned = 1'b0;
    assign hi_pend    = |hi_wstrb;
    // capture the upper beat at acceptance; a zero strobe means no second beat
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_addr  <= '0;
            hi_wdata <= '0;
            hi_wstrb <= '0;
        end else if (accept) begin
            hi_addr  <= {AddrM[31:2], 2'b00} + 32'd4;
            hi_wdata <= data64[63:32];
            hi_wstrb <= strb8[7:4];
        end
    end
`else
    logic unused_hi;
    assign unused_hi  = ^data64[63:32];
    assign misaligned = need_hi;
    assign hi_pend    = 1'b0;
`endif

    assign StallM           = StoreReqM && !final_hs && !(state == IDLE && misaligned);
    assign StoreDoneM       = !reset && final_hs;
    assign StoreMisalignedM = !reset && state == IDLE && StoreReqM && misaligned;

    // state and bus registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state     <= state_n;
            mem_valid <= valid_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_wstrb <= wstrb_n;
        end
    end

    // next state: issue lower beat on accept, advance or retire on each handshake, hold otherwise
    always_comb begin
        state_n = state;
        valid_n = mem_valid;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        wstrb_n = mem_wstrb;
        case (state)
            IDLE: if (accept) begin
                state_n = LO;
                valid_n = 1'b1;
                addr_n  = {AddrM[31:2], 2'b00};
                wdata_n = data64[31:0];
                wstrb_n = strb8[3:0];
            end
            default: if (final_hs) begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
            else if (hs) begin
                state_n = HI;
                addr_n  = hi_addr;
                wdata_n = hi_wdata;
                wstrb_n = hi_wstrb;
            end
`endif
        endcase
    end
endmodule

// File: tb/tb_store_alignment_unit.sv
// tb_store_alignment_unit: scoreboard bench for store_alignment_unit (both KIANV_MISALIGNED_STORE_SPLIT_EN builds)
module tb_store_alignment_unit;
    import riscv_defines::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, StoreReqM, mem_ready;
    StoreOp_t    StoreOpM;
    logic [31:0] AddrM, WriteDataM;
    logic        StallM, StoreDoneM, StoreMisalignedM, mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    beat_t exp_q[$];
    int checks = 0, errors = 0, done_seen = 0, mis_seen = 0;

    always #5 clk = ~clk;

    store_alignment_unit dut (
        .clk              (clk),
        .reset            (reset),
        .StoreReqM        (StoreReqM),
        .StoreOpM         (StoreOpM),
        .AddrM            (AddrM),
        .WriteDataM       (WriteDataM),
        .StallM           (StallM),
        .StoreDoneM       (StoreDoneM),
        .StoreMisalignedM (StoreMisalignedM),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wstrb        (mem_wstrb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back('{addr: a, wdata: d, wstrb: s});
    endtask

    // monitor: pops an expected beat per handshake, checks hold-while-stalled, counts pulses
    initial begin
        logic        pv = 1'b0;
        logic [31:0] pa = '0, pd = '0;
        logic [3:0]  ps = '0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (StoreDoneM) done_seen++;
                if (StoreMisalignedM) mis_seen++;
                if (pv) begin
                    chk("held_valid", {31'b0, mem_valid}, 32'd1);
                    chk("held_addr", mem_addr, pa);
                    chk("held_wdata", mem_wdata, pd);
                    chk("held_wstrb", {28'b0, mem_wstrb}, {28'b0, ps});
                end
                if (mem_valid && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got addr %h wdata %h expected no beat", mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_addr", mem_addr, e.addr);
                        chk("beat_wdata", mem_wdata, e.wdata);
                        chk("beat_wstrb", {28'b0, mem_wstrb}, {28'b0, e.wstrb});
                    end
                end
            end
            pv = mem_valid && !mem_ready && !reset;
            pa = mem_addr;
            pd = mem_wdata;
            ps = mem_wstrb;
        end
    end

    // drive one store until StallM drops; mem_ready is held low for 'hold' cycles of mem_valid
    task automatic do_store(input StoreOp_t op, input logic [31:0] a, input logic [31:0] d,
                            input int hold, input int exp_stall, input int exp_done, input int exp_mis);
        int stall_cnt = 0, waited = 0, d0 = done_seen, m0 = mis_seen;
        bit fin = 1'b0;
        StoreReqM  = 1'b1;
        StoreOpM   = op;
        AddrM      = a;
        WriteDataM = d;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (!StallM) fin = 1'b1;
            else begin
                stall_cnt++;
                @(posedge clk);
                #1;
                if (mem_valid && !mem_ready) begin
                    if (waited >= hold) mem_ready = 1'b1;
                    else waited++;
                end
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL store_timeout: addr %h still stalled expected completion", a);
        end
        @(posedge clk);
        #1;
        StoreReqM = 1'b0;
        mem_ready = 1'b0;
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("done_pulses", done_seen - d0, exp_done);
        chk("misaligned_pulses", mis_seen - m0, exp_mis);
    endtask

    initial begin
        int d0;
        reset      = 1'b1;
        StoreReqM  = 1'b0;
        StoreOpM   = STORE_SB;
        AddrM      = '0;
        WriteDataM = '0;
        mem_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_flags", {27'b0, mem_wstrb, StoreDoneM, StoreMisalignedM, StallM} & 32'h7F, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready_ignored", {30'b0, mem_valid, StoreDoneM}, 32'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;

        push(32'h0000_1000, 32'hAB00_0000, 4'b1000);
        do_store(STORE_SB, 32'h0000_1003, 32'h0000_00AB, 0, 1, 1, 0);
        push(32'h0000_2000, 32'hDEAD_BEEF, 4'b1111);
        do_store(STORE_SW, 32'h0000_2000, 32'hDEAD_BEEF, 3, 4, 1, 0);
        push(32'h0000_1000, 32'hCAFE_0000, 4'b1100);
        do_store(STORE_SH, 32'h0000_1002, 32'h0000_CAFE, 0, 1, 1, 0);
        push(32'h0000_1000, 32'h00AB_CD00, 4'b0110);
        do_store(STORE_SH, 32'h0000_1001, 32'h1234_ABCD, 0, 1, 1, 0);
        push(32'h0000_0000, 32'h0000_005A, 4'b0001);
        do_store(STORE_SB, 32'h0000_0000, 32'hFFFF_FF5A, 0, 1, 1, 0);
        push(32'hFFFF_FFFC, 32'h7700_0000, 4'b1000);
        do_store(STORE_SB, 32'hFFFF_FFFF, 32'h0000_0077, 0, 1, 1, 0);

`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
        push(32'h0000_3000, 32'h3344_0000, 4'b1100);
        push(32'h0000_3004, 32'h0000_1122, 4'b0011);
        do_store(STORE_SW, 32'h0000_3002, 32'h1122_3344, 0, 2, 1, 0);
        push(32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
        push(32'h0000_0000, 32'h0000_00BE, 4'b0001);
        do_store(STORE_SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 4, 1, 0);
`else
        do_store(STORE_SW, 32'h0000_3002, 32'h1122_3344, 0, 0, 0, 1);
        do_store(STORE_SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 0, 0, 1);
`endif

        d0 = done_seen;
        StoreReqM = 1'b1;
        StoreOpM  = STORE_SW;
`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
        push(32'h0000_5000, 32'hB2C3_D400, 4'b1110);
        AddrM      = 32'h0000_5001;
        WriteDataM = 32'hA1B2_C3D4;
        mem_ready  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, mem_valid}, 32'd1);
        chk("pre_rst_addr", mem_addr, 32'h0000_5004);
`else
        AddrM      = 32'h0000_5000;
        WriteDataM = 32'hA1B2_C3D4;
        mem_ready  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, mem_valid}, 32'd1);
        chk("pre_rst_addr", mem_addr, 32'h0000_5000);
`endif
        @(posedge clk);
        #1;
        reset     = 1'b1;
        StoreReqM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, mem_valid}, 32'd0);
        chk("post_rst_stall", {31'b0, StallM}, 32'd0);
        @(negedge clk);
        chk("post_rst_no_beat", {31'b0, mem_valid}, 32'd0);
        chk("post_rst_no_done", done_seen - d0, 32'd0);
        @(posedge clk);
        #1;

        push(32'h0000_6000, 32'hCAFE_BABE, 4'b1111);
        do_store(STORE_SW, 32'h0000_6000, 32'hCAFE_BABE, 1, 2, 1, 0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
